// File: rtl/pc_seq_pkg.sv
// Shared widths, enums and helpers for the PC sequencer and its return-address stack.
package pc_seq_pkg;

    localparam int PC_W      = 32;
    localparam int RAS_DEPTH = 8;
    localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
    localparam int RAS_CNT_W = RAS_PTR_W + 1;

    typedef enum logic [2:0] {
        PC4     = 3'b000,
        JUMP    = 3'b001,
        BRANCH  = 3'b010,
        CALLRS1 = 3'b011,
        RET     = 3'b100
    } pc_src_e;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        FLUSH = 2'b01,
        HALT  = 2'b10
    } seq_state_e;

    // Unused encodings fall back to sequential fetch.
    function automatic pc_src_e decode_src(input logic [2:0] raw);
        pc_src_e src;
        case (raw)
            3'b001:  src = JUMP;
            3'b010:  src = BRANCH;
            3'b011:  src = CALLRS1;
            3'b100:  src = RET;
            default: src = PC4;
        endcase
        return src;
    endfunction

    // Fetch addresses are word aligned; low two bits of any target are dropped.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push while full overwrites the oldest
// entry and sets a sticky overflow flag; a pop while empty is ignored.
module ras_stack
    import pc_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [PC_W-1:0]      push_data,
    output logic [PC_W-1:0]      top,
    output logic [RAS_CNT_W-1:0] depth,
    output logic                 overflow
);

    logic [PC_W-1:0]      r_mem [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] r_ptr;
    logic [RAS_CNT_W-1:0] r_depth;
    logic                 r_overflow;

    logic [RAS_PTR_W-1:0] w_top_idx;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_do_pop;

    // r_ptr is the next write slot, so the top lives one below it; when full
    // r_ptr has wrapped onto the oldest entry, which the next push replaces.
    always_comb begin
        w_top_idx = r_ptr - RAS_PTR_W'(1);
        w_full    = (r_depth == RAS_CNT_W'(RAS_DEPTH));
        w_empty   = (r_depth == '0);
        w_do_pop  = pop && !push && !w_empty;
    end

    assign top      = r_mem[w_top_idx];
    assign depth    = r_depth;
    assign overflow = r_overflow;

    // Pointer, occupancy and overflow bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr      <= '0;
            r_depth    <= '0;
            r_overflow <= 1'b0;
        end else if (push) begin
            r_ptr <= r_ptr + RAS_PTR_W'(1);
            if (w_full) begin
                r_overflow <= 1'b1;
            end else begin
                r_depth <= r_depth + RAS_CNT_W'(1);
            end
        end else if (w_do_pop) begin
            r_ptr   <= w_top_idx;
            r_depth <= r_depth - RAS_CNT_W'(1);
        end
    end

    // Entry storage; contents survive reset since depth gates their use.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            r_mem[r_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer with redirect handling, one-cycle flush after every
// redirect, and a call/return stack for ret prediction.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  RUN   | normal fetch; sequential or redirect per pc_source
//  FLUSH | one cycle after a redirect; kills the wrong-path fetch
//  HALT  | ret with empty stack; pc frozen, err set until reset
module pc_sequencer
    import pc_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic [2:0]           pc_source,
    input  logic                 is_call,
    input  logic [PC_W-1:0]      jump_target,
    input  logic [PC_W-1:0]      branch_target,
    input  logic [PC_W-1:0]      rs1_value,
    input  logic [PC_W-1:0]      link_addr,
    output logic [PC_W-1:0]      pc,
    output logic                 flush,
    output logic [RAS_CNT_W-1:0] ras_depth,
    output logic                 ras_overflow,
    output logic                 err
);

    seq_state_e           r_state;
    seq_state_e           w_state_nxt;
    logic [PC_W-1:0]      r_pc;
    logic [PC_W-1:0]      w_pc_nxt;
    logic [PC_W-1:0]      w_pc_inc;
    pc_src_e              w_src;
    logic                 w_push;
    logic                 w_pop;
    logic [PC_W-1:0]      w_ras_top;
    logic [RAS_CNT_W-1:0] w_ras_depth;
    logic                 w_ras_overflow;

    assign w_pc_inc = r_pc + PC_W'(4);
    assign w_src    = decode_src(pc_source);

    // Next-state, next-PC and stack-control decode; stall freezes everything.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        if (!stall) begin
            case (r_state)
                RUN: begin
                    case (w_src)
                        JUMP: begin
                            w_pc_nxt    = align_pc(jump_target);
                            w_push      = is_call;
                            w_state_nxt = FLUSH;
                        end
                        BRANCH: begin
                            w_pc_nxt    = align_pc(branch_target);
                            w_state_nxt = FLUSH;
                        end
                        CALLRS1: begin
                            w_pc_nxt    = align_pc(rs1_value);
                            w_push      = is_call;
                            w_state_nxt = FLUSH;
                        end
                        RET: begin
                            if (w_ras_depth == '0) begin
                                w_state_nxt = HALT;
                            end else begin
                                w_pc_nxt    = align_pc(w_ras_top);
                                w_pop       = 1'b1;
                                w_state_nxt = FLUSH;
                            end
                        end
                        default: begin
                            w_pc_nxt = w_pc_inc;
                        end
                    endcase
                end
                FLUSH: begin
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = RUN;
                end
                HALT: begin
                    w_state_nxt = HALT;
                end
                default: begin
                    w_state_nxt = RUN;
                end
            endcase
        end
    end

    // State and PC registers; reset beats stall and any pending flush/halt.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    ras_stack u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (link_addr),
        .top       (w_ras_top),
        .depth     (w_ras_depth),
        .overflow  (w_ras_overflow)
    );

    assign pc           = r_pc;
    assign flush        = (r_state == FLUSH);
    assign err          = (r_state == HALT);
    assign ras_depth    = w_ras_depth;
    assign ras_overflow = w_ras_overflow;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [2:0]  pc_source;
    logic        is_call;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [31:0] rs1_value;
    logic [31:0] link_addr;
    logic [31:0] pc;
    logic        flush;
    logic [3:0]  ras_depth;
    logic        ras_overflow;
    logic        err;

    int tests;
    int fails;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .pc_source     (pc_source),
        .is_call       (is_call),
        .jump_target   (jump_target),
        .branch_target (branch_target),
        .rs1_value     (rs1_value),
        .link_addr     (link_addr),
        .pc            (pc),
        .flush         (flush),
        .ras_depth     (ras_depth),
        .ras_overflow  (ras_overflow),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_flush,
                             input logic [3:0] e_depth, input logic e_ovf, input logic e_err);
        check({tag, ".pc"},    pc,                  e_pc);
        check({tag, ".flush"}, {31'b0, flush},      {31'b0, e_flush});
        check({tag, ".depth"}, {28'b0, ras_depth},  {28'b0, e_depth});
        check({tag, ".ovf"},   {31'b0, ras_overflow}, {31'b0, e_ovf});
        check({tag, ".err"},   {31'b0, err},        {31'b0, e_err});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        stall = 1'b0;
        pc_source = 3'b000;
        is_call = 1'b0;
        jump_target = '0;
        branch_target = '0;
        rs1_value = '0;
        link_addr = '0;

        // reset
        step();
        reset = 1'b0;
        check_all("reset", 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);

        // sequential fetch
        step(); check_all("seq4",  32'h4, 1'b0, 4'd0, 1'b0, 1'b0);
        step(); check_all("seq8",  32'h8, 1'b0, 4'd0, 1'b0, 1'b0);
        step(); check_all("seq12", 32'hC, 1'b0, 4'd0, 1'b0, 1'b0);
        step(); check_all("seq16", 32'h10, 1'b0, 4'd0, 1'b0, 1'b0);

        // jump with misaligned target; FLUSH ignores a call request
        pc_source = 3'b001; jump_target = 32'h103;
        step(); check_all("jump", 32'h100, 1'b1, 4'd0, 1'b0, 1'b0);
        is_call = 1'b1; link_addr = 32'hDEAD;
        step(); check_all("jump_flush", 32'h104, 1'b0, 4'd0, 1'b0, 1'b0);
        is_call = 1'b0; pc_source = 3'b000;

        // call via rs1, then ret
        pc_source = 3'b011; is_call = 1'b1; rs1_value = 32'h200; link_addr = 32'h14;
        step(); check_all("callrs1", 32'h200, 1'b1, 4'd1, 1'b0, 1'b0);
        pc_source = 3'b100; is_call = 1'b0;
        step(); check_all("call_flush", 32'h204, 1'b0, 4'd1, 1'b0, 1'b0);
        step(); check_all("ret", 32'h14, 1'b1, 4'd0, 1'b0, 1'b0);
        pc_source = 3'b000;
        step(); check_all("ret_flush", 32'h18, 1'b0, 4'd0, 1'b0, 1'b0);

        // is_call with branch must not push
        pc_source = 3'b010; is_call = 1'b1; branch_target = 32'h42;
        step(); check_all("br_call", 32'h40, 1'b1, 4'd0, 1'b0, 1'b0);
        pc_source = 3'b000; is_call = 1'b0;
        step(); check_all("br_flush", 32'h44, 1'b0, 4'd0, 1'b0, 1'b0);

        // unused encoding behaves as sequential
        pc_source = 3'b110;
        step(); check_all("src110", 32'h48, 1'b0, 4'd0, 1'b0, 1'b0);
        pc_source = 3'b000;

        // nine calls: last one overflows, oldest (0x4) lost
        for (int i = 0; i < 9; i++) begin
            pc_source = 3'b001; is_call = 1'b1; jump_target = 32'h1000;
            link_addr = 32'(4 * (i + 1));
            step();
            check_all("call9", 32'h1000, 1'b1, (i >= 7) ? 4'd8 : 4'(i + 1), (i == 8), 1'b0);
            pc_source = 3'b000; is_call = 1'b0;
            step();
            check_all("call9_fl", 32'h1004, 1'b0, (i >= 7) ? 4'd8 : 4'(i + 1), (i == 8), 1'b0);
        end

        // eight rets return 0x24 down to 0x8
        for (int j = 0; j < 8; j++) begin
            pc_source = 3'b100;
            step();
            check_all("ret8", 32'(32'h24 - 4 * j), 1'b1, 4'(7 - j), 1'b1, 1'b0);
            pc_source = 3'b000;
            step();
            check_all("ret8_fl", 32'(32'h28 - 4 * j), 1'b0, 4'(7 - j), 1'b1, 1'b0);
        end

        // ninth ret underflows into HALT
        pc_source = 3'b100;
        step(); check_all("halt", 32'hC, 1'b0, 4'd0, 1'b1, 1'b1);
        pc_source = 3'b001; jump_target = 32'h500;
        step(); check_all("halt_hold", 32'hC, 1'b0, 4'd0, 1'b1, 1'b1);

        // reset during HALT with stall held
        stall = 1'b1; reset = 1'b1;
        step(); check_all("rst_halt", 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        reset = 1'b0; stall = 1'b0; pc_source = 3'b000;
        step(); check_all("post_rst", 32'h4, 1'b0, 4'd0, 1'b0, 1'b0);

        // stall during branch request
        stall = 1'b1; pc_source = 3'b010; branch_target = 32'h80;
        step(); check_all("stall_br1", 32'h4, 1'b0, 4'd0, 1'b0, 1'b0);
        step(); check_all("stall_br2", 32'h4, 1'b0, 4'd0, 1'b0, 1'b0);
        stall = 1'b0;
        step(); check_all("br_taken", 32'h80, 1'b1, 4'd0, 1'b0, 1'b0);

        // stall during FLUSH; a call request is ignored
        stall = 1'b1; pc_source = 3'b011; is_call = 1'b1; rs1_value = 32'h300;
        step(); check_all("stall_fl1", 32'h80, 1'b1, 4'd0, 1'b0, 1'b0);
        step(); check_all("stall_fl2", 32'h80, 1'b1, 4'd0, 1'b0, 1'b0);
        stall = 1'b0; pc_source = 3'b000; is_call = 1'b0;
        step(); check_all("fl_done", 32'h84, 1'b0, 4'd0, 1'b0, 1'b0);

        // stalled call does not push
        stall = 1'b1; pc_source = 3'b011; is_call = 1'b1;
        step(); check_all("stall_call", 32'h84, 1'b0, 4'd0, 1'b0, 1'b0);
        stall = 1'b0; pc_source = 3'b000; is_call = 1'b0;

        // PC wraps modulo 2^32
        pc_source = 3'b001; jump_target = 32'hFFFF_FFFF;
        step(); check_all("jmp_top", 32'hFFFF_FFFC, 1'b1, 4'd0, 1'b0, 1'b0);
        pc_source = 3'b000;
        step(); check_all("wrap", 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL be driven by one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 stall  in  1  hold PC, state and return-address stack (RAS) this cycle.
REQ-005 pc_source  in  3  redirect select: 000 PC+4, 001 jump/call, 010 branch taken, 011 call-rs1, 100 ret; 101-111 treated as 000.
REQ-006 is_call  in  1  push link_addr; honoured only with pc_source 001 or 011.
REQ-007 jump_target  in  32  target for 001.
REQ-008 branch_target  in  32  target for 010.
REQ-009 rs1_value  in  32  target for 011.
REQ-010 link_addr  in  32  return address to push on a call.
REQ-011 pc  out  32  current fetch PC.
REQ-012 flush  out  1  kill the instruction fetched in the previous cycle.
REQ-013 ras_depth  out  4  valid RAS entries, 0..8.
REQ-014 ras_overflow  out  1  sticky: a push occurred while the RAS was full.
REQ-015 err  out  1  ret with empty RAS; sequencer is halted.

Function
REQ-016 States SHALL be RUN, FLUSH and HALT; reset enters RUN.
REQ-017 RUN, stall=0, pc_source=000: pc <= pc+4, modulo 2^32; state stays RUN.
REQ-018 RUN, stall=0, pc_source in {001,010,011,100}: pc <= selected target with bits [1:0] forced to 0; next state FLUSH.
REQ-019 Ret target SHALL be the RAS top entry; that entry is popped the same cycle.
REQ-020 A call (is_call=1, pc_source 001/011) SHALL push link_addr the same cycle the redirect is taken.
REQ-021 FLUSH SHALL last exactly one un-stalled cycle with flush=1; pc_source and is_call are ignored; pc <= pc+4; next state RUN.
REQ-022 flush SHALL be 0 in RUN and HALT.
REQ-023 stall=1 in any state: pc, state, RAS and flags hold; inputs ignored; flush holds its value.
REQ-024 Redirect-to-PC latency SHALL be one cycle: target visible on pc the edge after the request.
REQ-025 RAS SHALL be 8 entries deep and circular; a push when full overwrites the oldest entry, ras_depth stays 8 and ras_overflow sets.
REQ-026 A ret with ras_depth=0 SHALL enter HALT: pc frozen, err=1, RAS unchanged, until reset.
REQ-027 is_call with pc_source 000, 010 or 100 SHALL NOT push.
REQ-028 A push and pop never occur in the same cycle; pc_source is one-hot in effect.

Reset
REQ-029 On reset the block SHALL set pc=32'h0000_0000, state RUN, flush=0, ras_depth=0, ras_overflow=0, err=0, RAS pointer 0.
REQ-030 Reset SHALL override stall and any in-flight FLUSH or HALT in the same cycle; RAS contents need not clear.

Structure
REQ-031 Package pc_seq_pkg SHALL hold PC_W=32, RAS_DEPTH=8, the pc_src_e enum (PC4, JUMP, BRANCH, CALLRS1, RET) and the seq_state_e enum (RUN, FLUSH, HALT).
REQ-032 The RAS SHALL be a separate sub-module ras_stack with push, pop, top, depth and overflow ports; pc_sequencer instantiates it once.

Verification
REQ-033 Reset, then 3 cycles of pc_source=000 -> pc = 0, 4, 8, 12; flush=0 throughout.
REQ-034 At pc=0x10, jump_target=0x103 with pc_source=001 -> next pc=0x100; flush=1 for one cycle; then pc=0x104 in RUN.
REQ-035 Call with rs1_value=0x200 and link_addr=0x14, pc_source=011, is_call=1; after FLUSH issue ret (100) -> pc=0x200, ras_depth 1; then pc=0x14, ras_depth 0.
REQ-036 Nine calls with link_addr 0x4..0x24 -> ras_depth=8 and ras_overflow=1; eight rets return 0x24 down to 0x8; a ninth ret -> err=1 and pc frozen.
REQ-037 Assert stall during a branch request (branch_target=0x80) and during FLUSH -> pc and flush hold; the branch is not taken until stall drops.
REQ-038 Assert reset while in HALT with stall=1 -> next cycle pc=0, err=0, ras_depth=0, state RUN.
